regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl_pkg.sv | 25 ++
 rtl/regfile_wb_ctrl_scoreboard.sv | 56 +++++
 rtl/regfile_wb_ctrl.sv | 174 +++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Packages : rv32_pkg, saratoga_pkg
//  Brief    : Shared RV32 register-file types and the write-port arbiter
//             state encoding used by regfile_wb_ctrl.
//  Revision : 1.0  initial release
// ============================================================================

package rv32_pkg;
    localparam int REG_COUNT = 32;
    typedef logic [4:0]  gpr_addr_t;
    typedef logic [31:0] word;
endpackage

package saratoga_pkg;
    // IDLE: buffer empty, HELD: buffer waiting behind the pipeline,
    // FORCE: pipeline held off for one cycle so the buffer can drain.
    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_HELD  = 2'd1,
        WB_FORCE = 2'd2
    } wb_ctrl_state_t;
endpackage

`default_nettype wire

// File: rtl/regfile_wb_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : wb_scoreboard
//  Brief    : Busy bit per architectural register (x1..x31), one set port,
//             one clear port, three combinational hazard lookups.
//  Revision : 1.0  initial release
// ============================================================================

module wb_scoreboard
    import rv32_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      set_en,
    input  gpr_addr_t set_addr,
    input  logic      clr_en,
    input  gpr_addr_t clr_addr,
    input  gpr_addr_t rs1_addr,
    input  gpr_addr_t rs2_addr,
    input  gpr_addr_t rd_addr,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic      rd_busy
);

    logic [REG_COUNT-1:1] r_busy;
    logic [REG_COUNT-1:1] w_busy_next;
    logic [REG_COUNT-1:0] w_busy_full;

    // Clear first, then set, so a same-cycle reissue of a draining register stays busy
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 1; i < REG_COUNT; i++) begin
            if (clr_en && (clr_addr == gpr_addr_t'(i))) w_busy_next[i] = 1'b0;
            if (set_en && (set_addr == gpr_addr_t'(i))) w_busy_next[i] = 1'b1;
        end
    end

    // Busy vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // x0 is hard-wired not busy by padding bit 0 with zero
    assign w_busy_full = {r_busy, 1'b0};
    assign rs1_busy    = w_busy_full[rs1_addr];
    assign rs2_busy    = w_busy_full[rs2_addr];
    assign rd_busy     = w_busy_full[rd_addr];

endmodule

`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_ctrl
//  Brief    : Register-file write-port arbiter between the in-order pipeline
//             writeback and a one-entry buffer of long-latency results, with
//             a busy scoreboard that stalls decode on hazards.
//  Options  : REGFILE_WB_STARVE_GUARD_EN - adds the starvation counter and the
//             FORCE state that holds the pipeline so the buffer can drain.
//  Revision : 1.0  initial release
// ============================================================================

module regfile_wb_ctrl
    import rv32_pkg::*;
    import saratoga_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      iss_valid,
    input  logic      iss_long,
    input  gpr_addr_t iss_rs1,
    input  gpr_addr_t iss_rs2,
    input  gpr_addr_t iss_rd,
    output logic      iss_stall,
    input  logic      wb_en,
    input  gpr_addr_t wb_rd,
    input  word       wb_data,
    output logic      wb_stall,
    input  logic      lu_valid,
    input  gpr_addr_t lu_rd,
    input  word       lu_data,
    output logic      lu_ready,
    output logic      dest_en,
    output gpr_addr_t dest_addr,
    output word       dest_data
);

    localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);

    wb_ctrl_state_t r_state;
    wb_ctrl_state_t w_state_next;
    logic           r_buf_vld;
    gpr_addr_t      r_buf_rd;
    word            r_buf_data;

    logic w_capture;
    logic w_pipe_grant;
    logic w_buf_grant;
    logic w_issue_set;
    logic w_forced;
    logic w_rs1_busy;
    logic w_rs2_busy;
    logic w_rd_busy;

    assign lu_ready    = !r_buf_vld;
    assign w_capture   = lu_valid && !r_buf_vld;
    assign iss_stall   = iss_valid && (w_rs1_busy || w_rs2_busy || w_rd_busy);
    assign w_issue_set = iss_valid && iss_long && !iss_stall && (iss_rd != '0);

`ifdef REGFILE_WB_STARVE_GUARD_EN
    logic [7:0] r_starve_cnt;
    logic [7:0] w_starve_inc;

    assign w_forced     = (r_state == WB_FORCE);
    assign wb_stall     = w_forced;
    assign w_starve_inc = (r_starve_cnt == 8'hFF) ? r_starve_cnt : r_starve_cnt + 8'd1;

    // Count HELD cycles the buffer loses the port; any drain restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_buf_grant) begin
            r_starve_cnt <= '0;
        end else if (r_state == WB_HELD) begin
            r_starve_cnt <= w_starve_inc;
        end
    end
`else
    // Limit only matters when the starvation guard is built in
    logic w_unused_limit;
    assign w_unused_limit = ^c_STARVE_LIMIT;
    assign w_forced       = 1'b0;
    assign wb_stall       = 1'b0;
`endif

    // Port arbitration, write-port outputs and next state
    always_comb begin
        w_state_next = r_state;
        w_pipe_grant = 1'b0;
        w_buf_grant  = 1'b0;
        dest_en      = 1'b0;
        dest_addr    = '0;
        dest_data    = '0;

        // rst_n gates the pipeline path so nothing reaches the file during reset
        if (rst_n && !w_forced && wb_en && (wb_rd != '0)) begin
            w_pipe_grant = 1'b1;
        end else if (r_buf_vld) begin
            w_buf_grant = 1'b1;
        end

        if (w_pipe_grant) begin
            dest_en   = 1'b1;
            dest_addr = wb_rd;
            dest_data = wb_data;
        end else if (w_buf_grant) begin
            // A result aimed at x0 is consumed without writing
            dest_en   = (r_buf_rd != '0);
            dest_addr = r_buf_rd;
            dest_data = r_buf_data;
        end

        case (r_state)
            WB_IDLE: begin
                if (w_capture) w_state_next = WB_HELD;
            end
            WB_HELD: begin
                if (w_buf_grant) begin
                    w_state_next = WB_IDLE;
                end
`ifdef REGFILE_WB_STARVE_GUARD_EN
                else if (w_starve_inc >= c_STARVE_LIMIT) begin
                    w_state_next = WB_FORCE;
                end
`endif
            end
            WB_FORCE: w_state_next = WB_IDLE;
            default:  w_state_next = WB_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One-entry long-result buffer: fill when empty, free on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_vld  <= 1'b0;
            r_buf_rd   <= '0;
            r_buf_data <= '0;
        end else if (w_capture) begin
            r_buf_vld  <= 1'b1;
            r_buf_rd   <= lu_rd;
            r_buf_data <= lu_data;
        end else if (w_buf_grant) begin
            r_buf_vld  <= 1'b0;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (w_issue_set),
        .set_addr (iss_rd),
        .clr_en   (w_buf_grant && (r_buf_rd != '0)),
        .clr_addr (r_buf_rd),
        .rs1_addr (iss_rs1),
        .rs2_addr (iss_rs2),
        .rd_addr  (iss_rd),
        .rs1_busy (w_rs1_busy),
        .rs2_busy (w_rs2_busy),
        .rd_busy  (w_rd_busy)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_ctrl
//  Brief    : Self-checking bench for regfile_wb_ctrl: directed scenarios with
//             literal expectations plus randomized traffic against a
//             behavioural model of the scoreboard, buffer and arbitration.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps

module tb_regfile_wb_ctrl;

    localparam int LIMIT = 8;
`ifdef REGFILE_WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iss_valid, iss_long;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_stall;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        dest_en;
    logic [4:0]  dest_addr;
    logic [31:0] dest_data;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    regfile_wb_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_long  (iss_long),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_stall (iss_stall),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_stall  (wb_stall),
        .lu_valid  (lu_valid),
        .lu_rd     (lu_rd),
        .lu_data   (lu_data),
        .lu_ready  (lu_ready),
        .dest_en   (dest_en),
        .dest_addr (dest_addr),
        .dest_data (dest_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        iss_stall;
        logic        wb_stall;
        logic        lu_ready;
        logic        dest_en;
        logic [4:0]  dest_addr;
        logic [31:0] dest_data;
        logic        pipe_wins;
        logic        buf_drains;
    } exp_t;

    bit          m_busy [32];
    bit          m_buf_v = 1'b0;
    logic [4:0]  m_buf_rd = '0;
    logic [31:0] m_buf_d = '0;
    int          m_lost = 0;
    exp_t        m_e;
    exp_t        c_e;

    function automatic exp_t model_outputs();
        exp_t e;
        e = '0;
        if (!rst_n) begin
            e.lu_ready = 1'b1;
            return e;
        end
        e.lu_ready  = !m_buf_v;
        e.wb_stall  = GUARD && m_buf_v && (m_lost >= LIMIT);
        e.iss_stall = iss_valid && ((iss_rs1 != 0 && m_busy[iss_rs1]) ||
                                    (iss_rs2 != 0 && m_busy[iss_rs2]) ||
                                    (iss_rd  != 0 && m_busy[iss_rd]));
        e.pipe_wins  = !e.wb_stall && wb_en && (wb_rd != 0);
        e.buf_drains = m_buf_v && !e.pipe_wins;
        if (e.pipe_wins) begin
            e.dest_en = 1'b1; e.dest_addr = wb_rd; e.dest_data = wb_data;
        end else if (e.buf_drains) begin
            e.dest_en = (m_buf_rd != 0); e.dest_addr = m_buf_rd; e.dest_data = m_buf_d;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_buf_v = 1'b0; m_buf_rd = '0; m_buf_d = '0; m_lost = 0;
        end else begin
            m_e = model_outputs();
            if (m_buf_v && m_e.pipe_wins && m_lost < 255) m_lost = m_lost + 1;
            if (m_e.buf_drains) begin
                m_buf_v = 1'b0;
                m_lost  = 0;
                if (m_buf_rd != 0) m_busy[m_buf_rd] = 1'b0;
            end else if (lu_valid && m_e.lu_ready) begin
                m_buf_v = 1'b1; m_buf_rd = lu_rd; m_buf_d = lu_data; m_lost = 0;
            end
            if (iss_valid && iss_long && !m_e.iss_stall && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        if (chk_on) begin
            c_e = model_outputs();
            chk("m_iss_stall", {31'd0, iss_stall}, {31'd0, c_e.iss_stall});
            chk("m_wb_stall",  {31'd0, wb_stall},  {31'd0, c_e.wb_stall});
            chk("m_lu_ready",  {31'd0, lu_ready},  {31'd0, c_e.lu_ready});
            chk("m_dest_en",   {31'd0, dest_en},   {31'd0, c_e.dest_en});
            chk("m_dest_addr", {27'd0, dest_addr}, {27'd0, c_e.dest_addr});
            chk("m_dest_data", dest_data, c_e.dest_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_long = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
    endtask

    initial begin
        int w5;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        // Reset: outputs quiet even with live inputs
        wb_en = 1; wb_rd = 5'd3; wb_data = 32'h1111_1111; lu_valid = 1; lu_rd = 5'd2;
        at_neg();
        chk("rst_iss_stall", {31'd0, iss_stall}, 0);
        chk("rst_wb_stall",  {31'd0, wb_stall},  0);
        chk("rst_lu_ready",  {31'd0, lu_ready},  1);
        chk("rst_dest_en",   {31'd0, dest_en},   0);
        chk("rst_dest_addr", {27'd0, dest_addr}, 0);
        chk("rst_dest_data", dest_data, 0);
        step(); idle_inputs(); rst_n = 1'b1;

        // RAW hazard on a long op's destination
        w5 = 0;
        step(); iss_valid = 1; iss_long = 1; iss_rd = 5; iss_rs1 = 1; iss_rs2 = 2;
        at_neg(); chk("raw_issue_ok", {31'd0, iss_stall}, 0);
        step(); iss_long = 0; iss_rs1 = 5; iss_rs2 = 0; iss_rd = 6;
        at_neg(); chk("raw_stall_a", {31'd0, iss_stall}, 1); w5 += int'(dest_en && dest_addr == 5);
        step(); lu_valid = 1; lu_rd = 5; lu_data = 32'h0000_5555;
        at_neg(); chk("raw_stall_b", {31'd0, iss_stall}, 1); w5 += int'(dest_en && dest_addr == 5);
        step(); lu_valid = 0;
        at_neg(); chk("raw_stall_wr", {31'd0, iss_stall}, 1);
        chk("raw_wr_en", {31'd0, dest_en}, 1);
        chk("raw_wr_addr", {27'd0, dest_addr}, 5);
        w5 += int'(dest_en && dest_addr == 5);
        step();
        at_neg(); chk("raw_released", {31'd0, iss_stall}, 0); w5 += int'(dest_en && dest_addr == 5);
        step(); idle_inputs();
        at_neg(); w5 += int'(dest_en && dest_addr == 5);
        chk("raw_rd5_once", w5, 1);

        // Long result, idle pipeline: write one cycle after capture
        step(); lu_valid = 1; lu_rd = 7; lu_data = 32'hDEAD_BEEF;
        at_neg(); chk("lu7_ready_cap", {31'd0, lu_ready}, 1); chk("lu7_no_wr_yet", {31'd0, dest_en}, 0);
        step(); lu_valid = 0;
        at_neg();
        chk("lu7_en", {31'd0, dest_en}, 1);
        chk("lu7_addr", {27'd0, dest_addr}, 7);
        chk("lu7_data", dest_data, 32'hDEAD_BEEF);
        chk("lu7_ready_low", {31'd0, lu_ready}, 0);
        step();
        at_neg(); chk("lu7_ready_back", {31'd0, lu_ready}, 1); chk("lu7_done", {31'd0, dest_en}, 0);

        // Result to x0: discarded, scoreboard untouched
        step(); iss_valid = 1; iss_long = 1; iss_rd = 3;
        at_neg(); chk("x0_issue3", {31'd0, iss_stall}, 0);
        step(); idle_inputs(); lu_valid = 1; lu_rd = 0; lu_data = 32'h0000_1234;
        step(); lu_valid = 0;
        at_neg(); chk("x0_no_wr", {31'd0, dest_en}, 0); chk("x0_buf_full", {31'd0, lu_ready}, 0);
        step(); iss_valid = 1; iss_rs1 = 3; iss_rd = 8;
        at_neg(); chk("x0_freed", {31'd0, lu_ready}, 1); chk("x0_busy3_kept", {31'd0, iss_stall}, 1);
        step(); idle_inputs(); lu_valid = 1; lu_rd = 3; lu_data = 32'h3;
        step(); lu_valid = 0;
        at_neg(); chk("x0_clean_addr", {27'd0, dest_addr}, 3);
        step();

        // Starvation: pipeline writes every cycle while a result waits
        step(); lu_valid = 1; lu_rd = 4; lu_data = 32'hA5A5_A5A5;
        wb_en = 1; wb_rd = 3; wb_data = 32'h3333_3333;
        at_neg(); chk("stv_cap_pipe", {27'd0, dest_addr}, 3);
        step(); lu_valid = 0;
        for (int i = 0; i < LIMIT; i++) begin
            at_neg();
            chk("stv_lost_addr", {27'd0, dest_addr}, 3);
            chk("stv_lost_stall", {31'd0, wb_stall}, 0);
            step();
        end
        at_neg();
        chk("stv_force_stall", {31'd0, wb_stall}, GUARD ? 1 : 0);
        chk("stv_force_addr", {27'd0, dest_addr}, GUARD ? 4 : 3);
        chk("stv_force_data", dest_data, GUARD ? 32'hA5A5_A5A5 : 32'h3333_3333);
        step();
        at_neg();
        chk("stv_after_stall", {31'd0, wb_stall}, 0);
        chk("stv_after_addr", {27'd0, dest_addr}, 3);
        chk("stv_after_ready", {31'd0, lu_ready}, GUARD ? 1 : 0);
        step(); wb_en = 0;
        at_neg();
        chk("stv_tail_en", {31'd0, dest_en}, GUARD ? 0 : 1);
        chk("stv_tail_addr", {27'd0, dest_addr}, GUARD ? 0 : 4);
        step(); idle_inputs();

        // Same-cycle drain of x9 and new long issue to x9
        step(); lu_valid = 1; lu_rd = 9; lu_data = 32'h0000_9999;
        step(); lu_valid = 0; iss_valid = 1; iss_long = 1; iss_rd = 9;
        at_neg(); chk("same9_issue", {31'd0, iss_stall}, 0); chk("same9_drain", {27'd0, dest_addr}, 9);
        step(); iss_long = 0; iss_rs1 = 9; iss_rd = 10;
        at_neg(); chk("same9_busy", {31'd0, iss_stall}, 1);
        step(); idle_inputs(); lu_valid = 1; lu_rd = 9;
        step(); lu_valid = 0;
        step();

        // Reset while a result waits in HELD
        step(); iss_valid = 1; iss_long = 1; iss_rd = 13;
        step(); idle_inputs(); lu_valid = 1; lu_rd = 12; lu_data = 32'h00C0_FFEE;
        wb_en = 1; wb_rd = 2; wb_data = 32'h2222_2222;
        step(); lu_valid = 0; iss_valid = 1; iss_rs1 = 13; iss_rd = 14;
        at_neg(); chk("hrst_pre_stall", {31'd0, iss_stall}, 1); chk("hrst_pre_full", {31'd0, lu_ready}, 0);
        step(); rst_n = 1'b0;
        at_neg();
        chk("hrst_iss_stall", {31'd0, iss_stall}, 0);
        chk("hrst_wb_stall",  {31'd0, wb_stall},  0);
        chk("hrst_lu_ready",  {31'd0, lu_ready},  1);
        chk("hrst_dest_en",   {31'd0, dest_en},   0);
        chk("hrst_dest_addr", {27'd0, dest_addr}, 0);
        chk("hrst_dest_data", dest_data, 0);
        step(); rst_n = 1'b1; wb_en = 0;
        at_neg(); chk("hrst_discard", {31'd0, dest_en}, 0); chk("hrst_busy_clr", {31'd0, iss_stall}, 0);
        step(); idle_inputs();

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            step();
            rst_n     = ($urandom_range(0, 599) != 0);
            iss_valid = $urandom_range(0, 1);
            iss_long  = ($urandom_range(0, 2) == 0);
            iss_rs1   = 5'($urandom_range(0, 15));
            iss_rs2   = 5'($urandom_range(0, 15));
            iss_rd    = 5'($urandom_range(0, 15));
            wb_en     = ((n % 400) < 150) ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
            wb_rd     = 5'($urandom_range(0, 15));
            wb_data   = $urandom();
            lu_valid  = ($urandom_range(0, 2) == 0);
            lu_rd     = 5'($urandom_range(0, 15));
            lu_data   = $urandom();
        end
        step(); idle_inputs(); rst_n = 1'b1;
        repeat (2) at_neg();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
